// File: rtl/uart_tx_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_pkg
//   Shared definitions for the UART framing blocks: FSM state encoding, line
//   levels and the parity helper used when a byte is latched.
// -----------------------------------------------------------------------------
package uart_tx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_STOP = 3'd4
    } state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    // Parity over the low 'width' bits of 'data'.
    // Even parity makes the total count of ones even; odd inverts that.
    function automatic logic parity_bit(
        input logic [7:0]  data,
        input int unsigned width,
        input logic        odd
    );
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < width) begin
                p = p ^ data[i];
            end
        end
        return p ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_frame_bps_tick_det.sv
// -----------------------------------------------------------------------------
// bps_tick_det
//   Turns the baud square wave from BPS_timer into a one-clk_i-cycle pulse at
//   each rising edge. Shared between the transmit and receive framers.
// Ports
//   clk_i      system clock
//   rst_i      synchronous, active-high reset
//   clk_BPS_i  baud square wave, generated in the clk_i domain
//   tick_o     1-cycle pulse on each rising edge of clk_BPS_i
// -----------------------------------------------------------------------------
module bps_tick_det
    import uart_tx_frame_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clk_BPS_i,
    output logic tick_o
);

    logic bps_q;
    logic seen_low;

    // seen_low suppresses a false edge when clk_BPS_i is already high as reset
    // releases: bps_q is cleared by reset, so without it the first post-reset
    // cycle would look like a rising edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bps_q    <= 1'b0;
            seen_low <= 1'b0;
        end else begin
            bps_q <= clk_BPS_i;
            if (!clk_BPS_i) begin
                seen_low <= 1'b1;
            end
        end
    end

    assign tick_o = clk_BPS_i & ~bps_q & seen_low;

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   UART transmit framer. Accepts a byte on a valid/ready handshake and shifts
//   it out LSB first as start, data, optional parity and stop bits, one bit per
//   rising edge of the baud square wave.
// Parameters
//   DATA_BITS   payload bits per frame (5..8)
//   PARITY_EN   1 = insert a parity bit after the data bits
//   PARITY_ODD  1 = odd parity, 0 = even (only with PARITY_EN=1)
//   STOP_BITS   stop-bit count (1 or 2)
// Ports
//   clk_i      system clock
//   rst_i      synchronous, active-high reset; aborts any frame in flight
//   clk_BPS_i  baud square wave from BPS_timer
//   data_i     byte to send, sampled on accept
//   valid_i    data_i is valid
//   ready_o    framer idle and able to accept (accept = valid_i & ready_o)
//   tx_o       registered serial line, idle high
//   busy_o     frame in progress
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clk_BPS_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int unsigned          CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]     LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [1:0]           STOP_LAST = 2'(STOP_BITS);
    localparam logic                 HAS_PAR   = (PARITY_EN != 0);
    localparam logic                 ODD_PAR   = (PARITY_ODD != 0);

    state_t               state;
    state_t               state_nx;
    logic                 tick;
    logic                 accept;
    logic [DATA_BITS-1:0] sreg;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           stop_cnt;
    logic                 parity;
    logic                 tx;
    logic                 ready;

    bps_tick_det u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clk_BPS_i (clk_BPS_i),
        .tick_o    (tick)
    );

    assign accept = valid_i & ready;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. A tick coinciding with accept is ignored because
    // IDLE only looks at accept; ARM then waits a full baud period.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_ARM;
            ST_ARM:  if (tick)   state_nx = ST_DATA;
            ST_DATA: begin
                if (tick && (cnt == LAST_DATA)) begin
                    state_nx = HAS_PAR ? ST_PAR : ST_STOP;
                end
            end
            ST_PAR:  if (tick)   state_nx = ST_STOP;
            // Leave only on the tick after the last stop bit was driven,
            // so the final stop bit lasts a full baud period.
            ST_STOP: begin
                if (tick && (stop_cnt == STOP_LAST)) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state == ST_IDLE);
    end

    assign ready_o = ready;
    assign busy_o  = ~ready;
    assign tx_o    = tx;

    // Datapath: shift register, counters, parity and the registered line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx       <= UART_IDLE_LVL;
            sreg     <= '0;
            cnt      <= '0;
            stop_cnt <= '0;
            parity   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sreg     <= data_i;
                        parity   <= parity_bit(8'(data_i), DATA_BITS, ODD_PAR);
                        cnt      <= '0;
                        stop_cnt <= '0;
                    end
                end
                ST_ARM: begin
                    if (tick) begin
                        tx <= UART_START_LVL;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        tx   <= sreg[0];
                        sreg <= sreg >> 1;
                        cnt  <= cnt + 1'b1;
                    end
                end
                ST_PAR: begin
                    if (tick) begin
                        tx <= parity;
                    end
                end
                ST_STOP: begin
                    if (tick && (stop_cnt != STOP_LAST)) begin
                        tx       <= UART_IDLE_LVL;
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//   Four framer configurations share clock, reset and baud wave:
//   0 = 8N1, 1 = 8E1, 2 = 8O2, 3 = 8N2. Expected line contents are built from
//   the frame rules (start, LSB-first data, parity, stops) and checked bit
//   period by bit period against the baud phase the bench itself drives.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_bps = 1'b0;
    int         ph = 0;
    logic       valid [4];
    logic [7:0] data  [4];
    logic [3:0] tx;
    logic [3:0] ready;
    logic [3:0] busy;
    int         total = 0;
    int         bad = 0;

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .clk_BPS_i(clk_bps), .data_i(data[0]), .valid_i(valid[0]),
        .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]));
    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .clk_BPS_i(clk_bps), .data_i(data[1]), .valid_i(valid[1]),
        .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]));
    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .clk_BPS_i(clk_bps), .data_i(data[2]), .valid_i(valid[2]),
        .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]));
    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk_i(clk), .rst_i(rst), .clk_BPS_i(clk_bps), .data_i(data[3]), .valid_i(valid[3]),
        .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]));

    always #5 clk = ~clk;

    // Baud wave: 16 clk periods, 50% duty; rises on the negedge where ph wraps to 0.
    always @(negedge clk) begin
        ph = (ph + 1) % 16;
        clk_bps = (ph < 8);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int n_stop(input int i);
        return (i >= 2) ? 2 : 1;
    endfunction

    function automatic bit par_en(input int i);
        return (i == 1) || (i == 2);
    endfunction

    function automatic bit par_odd(input int i);
        return (i == 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_check(input int cycles, input string tag);
        logic [11:0] seen;
        seen = 12'hFF0;
        for (int c = 0; c < cycles; c++) begin
            step();
            if ({tx, ready, busy} !== 12'hFF0 && seen === 12'hFF0) seen = {tx, ready, busy};
        end
        check(tag, seen, 12'hFF0);
    endtask

    // Send byte b on instance idx and check the whole frame.
    // after: data_i value placed right after accept; hold: keep valid_i high;
    // abort_win: window in which to pulse reset (-1 = none); pulse: extra valid
    // pulse during the frame that must be dropped.
    task automatic send_frame(input int idx, input logic [7:0] b, input logic [7:0] after,
                              input bit hold, input int abort_win, input bit pulse);
        bit         q[$];
        int         ones;
        int         guard;
        logic       badv;
        logic [1:0] rb;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            q.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (par_en(idx)) q.push_back((ones % 2 == 1) ^ par_odd(idx));
        for (int i = 0; i < n_stop(idx); i++) q.push_back(1'b1);

        data[idx]  = b;
        valid[idx] = 1'b1;
        guard = 0;
        while (ready[idx] !== 1'b1 && guard < 400) begin
            step();
            guard++;
        end
        check($sformatf("accept_wait inst%0d", idx), 32'(guard < 400), 32'd1);
        if (guard >= 400) begin
            valid[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        step();
        if (!hold) valid[idx] = 1'b0;
        data[idx] = after;

        // Waiting for the first tick after accept; ready must already be low.
        rb = 2'b01;
        if ({ready[idx], busy[idx]} !== 2'b01) rb = {ready[idx], busy[idx]};
        while (ph != 0) begin
            step();
            if ({ready[idx], busy[idx]} !== 2'b01 && rb === 2'b01) rb = {ready[idx], busy[idx]};
        end

        for (int w = 0; w < q.size(); w++) begin
            badv = q[w];
            for (int s = 0; s < 16; s++) begin
                step();
                if (pulse && w == 4 && s == 3) begin
                    valid[idx] = 1'b1;
                    data[idx]  = 8'h33;
                end
                if (pulse && w == 4 && s == 4) valid[idx] = 1'b0;
                if (w == abort_win && s == 5) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    check($sformatf("abort_tx inst%0d", idx), 32'(tx[idx]), 32'd1);
                    check($sformatf("abort_ready inst%0d", idx), 32'(ready[idx]), 32'd1);
                    check($sformatf("abort_busy inst%0d", idx), 32'(busy[idx]), 32'd0);
                    return;
                end
                if (tx[idx] !== q[w] && badv === q[w]) badv = tx[idx];
                if ({ready[idx], busy[idx]} !== 2'b01 && rb === 2'b01) rb = {ready[idx], busy[idx]};
            end
            check($sformatf("inst%0d byte %02h bit%0d", idx, b, w), 32'(badv), 32'(q[w]));
        end
        check($sformatf("ready_low_in_frame inst%0d", idx), 32'(rb), 32'd1);
        step();
        check($sformatf("ready_after_frame inst%0d", idx),
              32'({ready[idx], busy[idx], tx[idx]}), 32'b101);
    endtask

    initial begin
        logic [7:0] rb8;
        logic [7:0] ra8;
        int         ridx;
        int         gap;
        for (int i = 0; i < 4; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end

        // Reset and idle
        rst = 1'b1;
        repeat (3) step();
        check("reset_state", 32'({tx, ready, busy}), 32'hFF0);
        rst = 1'b0;
        idle_check(100, "idle_100");

        // 8N1 0xA5
        send_frame(0, 8'hA5, 8'h00, 1'b0, -1, 1'b0);

        // Parity: even 0x03 -> 0, even 0x07 -> 1, odd 0x03 -> 1 (two stops)
        send_frame(1, 8'h03, 8'hFF, 1'b0, -1, 1'b0);
        send_frame(1, 8'h07, 8'h00, 1'b0, -1, 1'b0);
        send_frame(2, 8'h03, 8'h5A, 1'b0, -1, 1'b0);

        // Held valid: 0x55 then 0xAA back to back; dropped pulse in frame 2
        send_frame(0, 8'h55, 8'hAA, 1'b1, -1, 1'b0);
        send_frame(0, 8'hAA, 8'hC3, 1'b0, -1, 1'b1);
        idle_check(48, "no_buffered_pulse");

        // Two stop bits, all-zero payload
        send_frame(3, 8'h00, 8'hFF, 1'b0, -1, 1'b0);

        // Reset in the middle of the data bits, then a clean frame
        send_frame(0, 8'h00, 8'h00, 1'b0, 3, 1'b0);
        send_frame(0, 8'h3C, 8'h00, 1'b0, -1, 1'b0);

        // Random bytes on random instances with random idle gaps
        for (int r = 0; r < 10; r++) begin
            ridx = int'($urandom_range(0, 3));
            rb8  = 8'($urandom);
            ra8  = 8'($urandom);
            gap  = int'($urandom_range(0, 40));
            repeat (gap) step();
            send_frame(ridx, rb8, ra8, 1'b0, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
